// File: rtl/inst_sram_responder.sv
// Instruction-SRAM responder: single-port word memory, 1-cycle registered read.
// Optional access counters compiled in with `INST_SRAM_ACC_CNT_EN`.
module inst_sram_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'hBFC0_0000,
    parameter int unsigned DEPTH_LOG2 = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    output logic        err_oor
`ifdef INST_SRAM_ACC_CNT_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    localparam int unsigned WORDS = 1 << DEPTH_LOG2;
    localparam logic [32:0] SPAN  = 33'(WORDS) * 33'd4;

    logic [31:0]           mem_q [WORDS];
    logic [31:0]           offset;
    logic                  in_range;
    logic                  is_wr;
    logic                  acc;
    logic [DEPTH_LOG2-1:0] idx;

    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Below-base addresses wrap to huge offsets and fall out of range.
    assign offset   = inst_sram_addr - BASE_ADDR;
    assign in_range = {1'b0, offset} < SPAN;
    assign idx      = inst_sram_addr[DEPTH_LOG2+1:2];
    assign is_wr    = |inst_sram_wen;
    assign acc      = inst_sram_en & in_range;

    always_ff @(posedge clock) begin
        if (acc && is_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (inst_sram_wen[b]) begin
                    mem_q[idx][8*b +: 8] <= inst_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (inst_sram_en) begin
            if (in_range) begin
                rdata_d = mem_q[idx];
            end else begin
                rdata_d = 32'h0;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign inst_sram_rdata = rdata_q;
    assign err_oor         = err_q;

`ifdef INST_SRAM_ACC_CNT_EN
    logic [15:0] rd_q, rd_d;
    logic [15:0] wr_q, wr_d;

    always_comb begin
        rd_d = rd_q;
        wr_d = wr_q;
        if (acc && !is_wr && rd_q != 16'hFFFF) begin
            rd_d = rd_q + 16'd1;
        end
        if (acc && is_wr && wr_q != 16'hFFFF) begin
            wr_d = wr_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_q <= 16'h0;
            wr_q <= 16'h0;
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
        end
    end

    assign rd_count = rd_q;
    assign wr_count = wr_q;
`endif

endmodule
